cnt_bus_arbiter: RTL

CNT_BUS_ARBITER -- requirements
Module: cnt_bus_arbiter

---
 rtl/cnt_bus_arbiter_if.sv | 10 +
 rtl/cnt_bus_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/cnt_bus_arbiter_if.sv
// Shared controller-register BRAM port: registered command out, read data in.
interface cnt_bus_if;
    logic        WE;
    logic [7:0]  ADDR;
    logic [15:0] DIN;
    logic [15:0] DOUT;

    modport out_port (output WE, output ADDR, output DIN, input DOUT);
    modport mem_port (input WE, input ADDR, input DIN, output DOUT);
endinterface

// File: rtl/cnt_bus_arbiter.sv
// Two-port arbiter for the controller-register BRAM: fixed A-first priority
// with a starvation counter for B, per-port bus locking, and a read tag
// pipeline that routes returning data to the port that issued the read.
module cnt_bus_arbiter #(
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned MAX_WAIT     = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        A_REQ,
    input  logic        A_WE,
    input  logic        A_LOCK,
    input  logic [7:0]  A_ADDR,
    input  logic [15:0] A_DIN,
    output logic        A_GNT,
    output logic        A_RVALID,
    output logic [15:0] A_RDATA,
    input  logic        B_REQ,
    input  logic        B_WE,
    input  logic        B_LOCK,
    input  logic [7:0]  B_ADDR,
    input  logic [15:0] B_DIN,
    output logic        B_GNT,
    output logic        B_RVALID,
    output logic [15:0] B_RDATA,
    cnt_bus_if.out_port cnt_bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] OWN_A = 2'd1;
    localparam logic [1:0] OWN_B = 2'd2;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    logic [1:0]  state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        own_a, own_b;
    logic        a_gnt, b_gnt;
    logic        we_q;
    logic [7:0]  addr_q;
    logic [15:0] din_q;
    logic [READ_LATENCY:0] tag_v_q;
    logic [READ_LATENCY:0] tag_p_q;
    logic        issue_rd;

    // A lock only holds ownership while LOCK stays high; the cycle it drops
    // the port is treated as idle so arbitration resumes immediately.
    assign own_a = (state_q == OWN_A) && A_LOCK;
    assign own_b = (state_q == OWN_B) && B_LOCK;

    // Grant decision: owner first, else A-first with forced B after MAX_WAIT
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!RST) begin
            if (own_a) begin
                a_gnt = A_REQ;
            end else if (own_b) begin
                b_gnt = B_REQ;
            end else if (A_REQ && B_REQ) begin
                if (wait_cnt_q == MAX_WAIT_C) begin
                    b_gnt = 1'b1;
                end else begin
                    a_gnt = 1'b1;
                end
            end else begin
                a_gnt = A_REQ;
                b_gnt = B_REQ;
            end
        end
    end

    // Owner and starvation-counter next-state
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        if (!(own_a || own_b)) begin
            if (a_gnt && A_LOCK) begin
                state_d = OWN_A;
            end else if (b_gnt && B_LOCK) begin
                state_d = OWN_B;
            end else begin
                state_d = IDLE;
            end
        end
        if (b_gnt || !B_REQ) begin
            wait_cnt_d = '0;
        end else if (a_gnt && !own_a) begin
            wait_cnt_d = (wait_cnt_q == MAX_WAIT_C) ? MAX_WAIT_C : wait_cnt_q + 8'd1;
        end
    end

    // Owner FSM and wait counter registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Register the granted command onto the bus; ADDR/DIN hold when idle
    always_ff @(posedge CLK) begin
        if (RST) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
        end else if (a_gnt) begin
            we_q   <= A_WE;
            addr_q <= A_ADDR;
            din_q  <= A_DIN;
        end else if (b_gnt) begin
            we_q   <= B_WE;
            addr_q <= B_ADDR;
            din_q  <= B_DIN;
        end else begin
            we_q   <= 1'b0;
        end
    end

    assign issue_rd = (a_gnt && !A_WE) || (b_gnt && !B_WE);

    // Read tag pipeline: slot 0 aligns with the bus cycle, slot READ_LATENCY with DOUT
    always_ff @(posedge CLK) begin
        if (RST) begin
            tag_v_q <= '0;
            tag_p_q <= '0;
        end else begin
            tag_v_q <= {tag_v_q[READ_LATENCY-1:0], issue_rd};
            tag_p_q <= {tag_p_q[READ_LATENCY-1:0], b_gnt};
        end
    end

    assign A_GNT    = a_gnt;
    assign B_GNT    = b_gnt;
    assign A_RVALID = !RST && tag_v_q[READ_LATENCY] && !tag_p_q[READ_LATENCY];
    assign B_RVALID = !RST && tag_v_q[READ_LATENCY] &&  tag_p_q[READ_LATENCY];
    assign A_RDATA  = A_RVALID ? cnt_bus.DOUT : '0;
    assign B_RDATA  = B_RVALID ? cnt_bus.DOUT : '0;

    assign cnt_bus.WE   = we_q && !RST;
    assign cnt_bus.ADDR = RST ? '0 : addr_q;
    assign cnt_bus.DIN  = RST ? '0 : din_q;

endmodule
